fpga_link_scheduler: RTL and testbench

Frame scheduler for the FPGA-to-FPGA serial word link on the slave board. Once per programmed frame period it snapshots the application's three 4-bit words and issues the start pulse to the exchange logic. It generates the bit-rate sync ticks for the exchange and watches for completion, with timeout and bounded retry. It sits between the control/application logic and the link exchange block, and reports per-frame status and a saturating error count.

---
 rtl/fpga_link_scheduler.sv | 106 ++++++++++
 tb/tb_fpga_link_scheduler.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_link_scheduler.sv
// fpga_link_scheduler: per-slot start, sync ticks, timeout and error accounting for the board link; FPGA_LINK_SCHED_RETRY_EN adds RECOVER/retry
module fpga_link_scheduler #(
  parameter int PERIOD_W = 16,
  parameter int TIMEOUT_BITS = 24,
  parameter int MAX_RETRY = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [7:0]          bit_rate,
  input  logic [PERIOD_W-1:0] frame_period,
  input  logic [3:0]          app_w1,
  input  logic [3:0]          app_w2,
  input  logic [3:0]          app_w3,
  input  logic                app_valid,
  input  logic                link_done,
  output logic [3:0]          tx_w1,
  output logic [3:0]          tx_w2,
  output logic [3:0]          tx_w3,
  output logic                start_link,
  output logic                sync_tick,
  output logic                busy,
  output logic                frame_ok,
  output logic                timeout_err,
  output logic                frame_overrun,
  output logic [7:0]          err_count
);
  localparam int BW = $clog2(TIMEOUT_BITS + 1);
`ifdef FPGA_LINK_SCHED_RETRY_EN
  localparam int RW = $clog2(MAX_RETRY + 2);
  typedef enum logic [1:0] {IDLE, START, BUSY, RECOVER} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, BUSY} state_t;
`endif
  state_t state, state_n;
  logic [PERIOD_W-1:0] per_cnt;
  logic [3:0] sh_w1, sh_w2, sh_w3;
  logic [7:0] rate_q;
  logic [8:0] div;
  logic [BW-1:0] bits;
  logic [8:0] err_sum;
  logic bound, tick, done_hit, to_hit, ovr_hit, in_rec;
  assign bound = enable && per_cnt == frame_period;
  assign tick = state == BUSY && div == {1'b0, rate_q} - 9'd1;
  assign done_hit = state == BUSY && link_done;
  assign to_hit = tick && !link_done && bits == BW'(TIMEOUT_BITS - 1);
  assign ovr_hit = bound && state != IDLE;
  assign err_sum = {1'b0, err_count} + {8'd0, to_hit} + {8'd0, ovr_hit};
  assign start_link = state == START;
  assign sync_tick = tick;
  assign busy = state != IDLE;
`ifdef FPGA_LINK_SCHED_RETRY_EN
  logic [RW-1:0] retry;
  logic rec_done;
  assign in_rec = state == RECOVER;
  assign rec_done = in_rec && div == {rate_q, 1'b0} - 9'd1;
  always_ff @(posedge clk)
    if (rst || state == IDLE) retry <= '0;
    else if (rec_done && state_n == START) retry <= retry + 1'b1;
`else
  assign in_rec = 1'b0;
`endif
  always_comb begin
    state_n = state;
    if (state == IDLE && bound) state_n = START;
    else if (state == START) state_n = BUSY;
    else if (done_hit) state_n = IDLE;
`ifdef FPGA_LINK_SCHED_RETRY_EN
    else if (to_hit) state_n = RECOVER;
    else if (rec_done) state_n = retry < RW'(MAX_RETRY) ? START : IDLE;
`else
    else if (to_hit) state_n = IDLE;
`endif
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      per_cnt <= '0;
      {sh_w1, sh_w2, sh_w3} <= '0;
      {tx_w1, tx_w2, tx_w3} <= '0;
      rate_q <= '0;
      div <= '0;
      bits <= '0;
      frame_ok <= 1'b0;
      timeout_err <= 1'b0;
      frame_overrun <= 1'b0;
      err_count <= '0;
    end else begin
      per_cnt <= (!enable || per_cnt >= frame_period) ? '0 : per_cnt + 1'b1;
      if (app_valid) {sh_w1, sh_w2, sh_w3} <= {app_w1, app_w2, app_w3};
      if (state == START) begin
        {tx_w1, tx_w2, tx_w3} <= app_valid ? {app_w1, app_w2, app_w3} : {sh_w1, sh_w2, sh_w3};
        rate_q <= bit_rate < 8'd2 ? 8'd2 : bit_rate;
      end
      // one divider serves both the tick spacing in BUSY and the RECOVER hold
      div <= ((state == BUSY && !tick) || in_rec) ? div + 9'd1 : 9'd0;
      bits <= state == START ? '0 : bits + BW'(tick);
      frame_ok <= done_hit;
      timeout_err <= to_hit;
      frame_overrun <= ovr_hit;
      err_count <= err_sum[8] ? 8'hFF : err_sum[7:0];
    end
  end
endmodule

// File: tb/tb_fpga_link_scheduler.sv
// tb_fpga_link_scheduler: scoreboard bench comparing timed link events against expected schedules
module tb_fpga_link_scheduler;
`ifdef FPGA_LINK_SCHED_RETRY_EN
  localparam int RETRIES = 3;
`else
  localparam int RETRIES = 0;
`endif
  logic clk = 0, rst = 1, enable = 0, app_valid = 0, link_done = 0;
  logic [7:0] bit_rate = 8'd4;
  logic [15:0] frame_period = 16'd199;
  logic [3:0] app_w1 = 0, app_w2 = 0, app_w3 = 0;
  logic [3:0] tx_w1, tx_w2, tx_w3;
  logic start_link, sync_tick, busy, frame_ok, timeout_err, frame_overrun;
  logic [7:0] err_count;
  int cyc = 0, n_tests = 0, n_fail = 0, t_rst = 0, resp_dly = 0, done_at = -1, ext_done_at = -1;
  int ev_q[$];

  fpga_link_scheduler dut (
    .clk(clk), .rst(rst), .enable(enable), .bit_rate(bit_rate), .frame_period(frame_period),
    .app_w1(app_w1), .app_w2(app_w2), .app_w3(app_w3), .app_valid(app_valid), .link_done(link_done),
    .tx_w1(tx_w1), .tx_w2(tx_w2), .tx_w3(tx_w3), .start_link(start_link), .sync_tick(sync_tick),
    .busy(busy), .frame_ok(frame_ok), .timeout_err(timeout_err), .frame_overrun(frame_overrun),
    .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // exchange-block stand-in plus event monitor; event code = cycle*8 + kind
  initial forever begin
    @(negedge clk);
    link_done = cyc == done_at || cyc == ext_done_at;
    if (start_link && resp_dly > 0) done_at = cyc + resp_dly;
    if (start_link) ev_q.push_back(cyc * 8);
    if (sync_tick) ev_q.push_back(cyc * 8 + 1);
    if (frame_ok) ev_q.push_back(cyc * 8 + 2);
    if (timeout_err) ev_q.push_back(cyc * 8 + 3);
    if (frame_overrun) ev_q.push_back(cyc * 8 + 4);
  end

  task automatic do_reset(input int p, input int r, input logic en);
    @(negedge clk);
    rst = 1; frame_period = 16'(p); bit_rate = 8'(r); enable = en;
    resp_dly = 0; app_valid = 0; done_at = -1; ext_done_at = -1; t_rst = cyc;
    @(negedge clk);
    rst = 0; ev_q.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if ({start_link, sync_tick, busy, frame_ok, timeout_err, frame_overrun} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000000", {start_link, sync_tick, busy, frame_ok, timeout_err, frame_overrun});
    end
    n_tests++;
    if ({tx_w1, tx_w2, tx_w3} !== 12'h000) begin
      n_fail++; $display("FAIL reset_tx: got %h expected 000", {tx_w1, tx_w2, tx_w3});
    end
    n_tests++;
    if (err_count !== 8'd0) begin
      n_fail++; $display("FAIL reset_err: got %0d expected 0", err_count);
    end
    rst = 0; ev_q.delete();
    repeat (300) @(negedge clk);
    n_tests++;
    if (ev_q.size() != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_disabled: got %0d events busy %b expected 0 events busy 0", ev_q.size(), busy);
    end
  endtask

  task automatic test_frames();
    int ex[$]; int s0, w, s, got, err;
    do_reset(199, 4, 1); resp_dly = 60;
    s0 = t_rst + 201; w = s0 + 470;
    for (int k = 0; k < 3; k++) begin
      s = s0 + 200 * k;
      ex.push_back(s * 8);
      for (int j = 1; j <= 15; j++) ex.push_back((s + 4 * j) * 8 + 1);
      ex.push_back((s + 61) * 8 + 2);
    end
    ex.sort();
    while (cyc < w) @(negedge clk);
    err = int'(err_count);
    @(negedge clk);
    while (ev_q.size() > 0 && ev_q[ev_q.size() - 1] / 8 > w) ev_q.delete(ev_q.size() - 1);
    foreach (ex[i]) begin
      got = -1; if (ev_q.size() > 0) got = ev_q.pop_front();
      n_tests++;
      if (got !== ex[i]) begin
        n_fail++; $display("FAIL frames ev%0d: got cyc %0d kind %0d, expected cyc %0d kind %0d", i, got / 8, got % 8, ex[i] / 8, ex[i] % 8);
      end
    end
    n_tests++;
    if (ev_q.size() != 0) begin n_fail++; $display("FAIL frames_extra: got %0d extra events expected 0", ev_q.size()); end
    n_tests++;
    if (err != 0) begin n_fail++; $display("FAIL frames_err: got %0d expected 0", err); end
  endtask

  task automatic test_bypass();
    int s0;
    do_reset(199, 4, 1); resp_dly = 60; s0 = t_rst + 201;
    repeat (5) @(negedge clk);
    app_valid = 1; {app_w1, app_w2, app_w3} = 12'hABC;
    @(negedge clk); app_valid = 0;
    while (cyc < s0 - 1) @(negedge clk);
    n_tests++;
    if ({tx_w1, tx_w2, tx_w3} !== 12'h000) begin n_fail++; $display("FAIL bypass_pre: got %h expected 000", {tx_w1, tx_w2, tx_w3}); end
    @(negedge clk);
    n_tests++;
    if (start_link !== 1'b1) begin n_fail++; $display("FAIL bypass_start: got %b expected 1", start_link); end
    app_valid = 1; {app_w1, app_w2, app_w3} = 12'h57D;
    @(negedge clk); app_valid = 0;
    n_tests++;
    if ({tx_w1, tx_w2, tx_w3} !== 12'h57D) begin n_fail++; $display("FAIL bypass_load: got %h expected 57d", {tx_w1, tx_w2, tx_w3}); end
    while (cyc < s0 + 10) @(negedge clk);
    app_valid = 1; {app_w1, app_w2, app_w3} = 12'h123;
    @(negedge clk); app_valid = 0;
    n_tests++;
    if ({tx_w1, tx_w2, tx_w3} !== 12'h57D) begin n_fail++; $display("FAIL bypass_hold: got %h expected 57d", {tx_w1, tx_w2, tx_w3}); end
    while (cyc < s0 + 199) @(negedge clk);
    n_tests++;
    if ({tx_w1, tx_w2, tx_w3} !== 12'h57D) begin n_fail++; $display("FAIL bypass_hold_long: got %h expected 57d", {tx_w1, tx_w2, tx_w3}); end
    repeat (2) @(negedge clk);
    n_tests++;
    if ({tx_w1, tx_w2, tx_w3} !== 12'h123) begin n_fail++; $display("FAIL bypass_next: got %h expected 123", {tx_w1, tx_w2, tx_w3}); end
  endtask

  task automatic test_timeout_retry();
    int ex[$]; int s0, w, s, got, err; logic b;
    do_reset(999, 2, 1); s0 = t_rst + 1001; w = s0 + 1100;
    for (int a = 0; a <= RETRIES; a++) begin
      s = s0 + 53 * a;
      ex.push_back(s * 8);
      for (int j = 1; j <= 24; j++) ex.push_back((s + 2 * j) * 8 + 1);
      ex.push_back((s + 49) * 8 + 3);
    end
    ex.sort();
    while (cyc < s0 + 1) @(negedge clk);
    enable = 0;
    while (cyc < w) @(negedge clk);
    err = int'(err_count); b = busy;
    @(negedge clk);
    while (ev_q.size() > 0 && ev_q[ev_q.size() - 1] / 8 > w) ev_q.delete(ev_q.size() - 1);
    foreach (ex[i]) begin
      got = -1; if (ev_q.size() > 0) got = ev_q.pop_front();
      n_tests++;
      if (got !== ex[i]) begin
        n_fail++; $display("FAIL retry ev%0d: got cyc %0d kind %0d, expected cyc %0d kind %0d", i, got / 8, got % 8, ex[i] / 8, ex[i] % 8);
      end
    end
    n_tests++;
    if (ev_q.size() != 0) begin n_fail++; $display("FAIL retry_extra: got %0d extra events expected 0", ev_q.size()); end
    n_tests++;
    if (err != RETRIES + 1 || b !== 1'b0) begin
      n_fail++; $display("FAIL retry_end: got err %0d busy %b expected err %0d busy 0", err, b, RETRIES + 1);
    end
  endtask

  task automatic test_overrun();
    int ex[$]; int s, w, t, e, b, got, err, nerr;
    do_reset(50, 4, 1);
    s = t_rst + 52; w = t_rst + 1000; nerr = 0;
    while (s <= w) begin
      for (int a = 0; a <= RETRIES; a++) begin
        t = s + a * 105;
        if (t <= w) ex.push_back(t * 8);
        for (int j = 1; j <= 24; j++) if (t + 4 * j <= w) ex.push_back((t + 4 * j) * 8 + 1);
        if (t + 97 <= w) begin ex.push_back((t + 97) * 8 + 3); nerr++; end
      end
      e = s + RETRIES * 105 + 96 + (RETRIES > 0 ? 8 : 0);
      b = s + 50;
      while (b <= e) begin
        if (b + 1 <= w) begin ex.push_back((b + 1) * 8 + 4); nerr++; end
        b += 51;
      end
      s = b + 1;
    end
    ex.sort();
    while (cyc < w) @(negedge clk);
    err = int'(err_count);
    @(negedge clk);
    while (ev_q.size() > 0 && ev_q[ev_q.size() - 1] / 8 > w) ev_q.delete(ev_q.size() - 1);
    foreach (ex[i]) begin
      got = -1; if (ev_q.size() > 0) got = ev_q.pop_front();
      n_tests++;
      if (got !== ex[i]) begin
        n_fail++; $display("FAIL overrun ev%0d: got cyc %0d kind %0d, expected cyc %0d kind %0d", i, got / 8, got % 8, ex[i] / 8, ex[i] % 8);
      end
    end
    n_tests++;
    if (ev_q.size() != 0) begin n_fail++; $display("FAIL overrun_extra: got %0d extra events expected 0", ev_q.size()); end
    n_tests++;
    if (err != (nerr > 255 ? 255 : nerr)) begin n_fail++; $display("FAIL overrun_err: got %0d expected %0d", err, nerr); end
  endtask

  task automatic test_done_at_timeout();
    int ex[$]; int s0, w, got, err;
    do_reset(999, 0, 1); ext_done_at = t_rst + 20; resp_dly = 48;
    s0 = t_rst + 1001; w = s0 + 100;
    ex.push_back(s0 * 8);
    for (int j = 1; j <= 24; j++) ex.push_back((s0 + 2 * j) * 8 + 1);
    ex.push_back((s0 + 49) * 8 + 2);
    ex.sort();
    while (cyc < w) @(negedge clk);
    err = int'(err_count);
    @(negedge clk);
    while (ev_q.size() > 0 && ev_q[ev_q.size() - 1] / 8 > w) ev_q.delete(ev_q.size() - 1);
    foreach (ex[i]) begin
      got = -1; if (ev_q.size() > 0) got = ev_q.pop_front();
      n_tests++;
      if (got !== ex[i]) begin
        n_fail++; $display("FAIL done_race ev%0d: got cyc %0d kind %0d, expected cyc %0d kind %0d", i, got / 8, got % 8, ex[i] / 8, ex[i] % 8);
      end
    end
    n_tests++;
    if (ev_q.size() != 0) begin n_fail++; $display("FAIL done_race_extra: got %0d extra events expected 0", ev_q.size()); end
    n_tests++;
    if (err != 0) begin n_fail++; $display("FAIL done_race_err: got %0d expected 0", err); end
  endtask

  task automatic test_saturation();
    do_reset(1, 2, 1);
    repeat (800) @(negedge clk);
    n_tests++;
    if (err_count !== 8'd255) begin n_fail++; $display("FAIL sat_reach: got %0d expected 255", err_count); end
    repeat (50) @(negedge clk);
    n_tests++;
    if (err_count !== 8'd255) begin n_fail++; $display("FAIL sat_hold: got %0d expected 255", err_count); end
  endtask

  task automatic test_rst_mid();
    int ex[$]; int s0, rr, w, got;
    do_reset(99, 4, 1);
    @(negedge clk); app_valid = 1; {app_w1, app_w2, app_w3} = 12'h9AB;
    @(negedge clk); app_valid = 0;
    s0 = t_rst + 101;
    while (cyc < s0 + 20) @(negedge clk);
    n_tests++;
    if (busy !== 1'b1 || {tx_w1, tx_w2, tx_w3} !== 12'h9AB) begin
      n_fail++; $display("FAIL rst_mid_pre: got busy %b tx %h expected busy 1 tx 9ab", busy, {tx_w1, tx_w2, tx_w3});
    end
    rst = 1; rr = cyc;
    @(negedge clk);
    rst = 0; ev_q.delete();
    n_tests++;
    if ({start_link, sync_tick, busy, frame_ok, timeout_err, frame_overrun} !== 6'b0) begin
      n_fail++; $display("FAIL rst_mid_flags: got %b expected 000000", {start_link, sync_tick, busy, frame_ok, timeout_err, frame_overrun});
    end
    n_tests++;
    if ({tx_w1, tx_w2, tx_w3, err_count} !== 20'h0) begin
      n_fail++; $display("FAIL rst_mid_regs: got tx %h err %0d expected tx 000 err 0", {tx_w1, tx_w2, tx_w3}, err_count);
    end
    w = rr + 111;
    ex.push_back((rr + 101) * 8);
    ex.push_back((rr + 105) * 8 + 1);
    ex.push_back((rr + 109) * 8 + 1);
    while (cyc < w) @(negedge clk);
    @(negedge clk);
    while (ev_q.size() > 0 && ev_q[ev_q.size() - 1] / 8 > w) ev_q.delete(ev_q.size() - 1);
    foreach (ex[i]) begin
      got = -1; if (ev_q.size() > 0) got = ev_q.pop_front();
      n_tests++;
      if (got !== ex[i]) begin
        n_fail++; $display("FAIL rst_mid ev%0d: got cyc %0d kind %0d, expected cyc %0d kind %0d", i, got / 8, got % 8, ex[i] / 8, ex[i] % 8);
      end
    end
    n_tests++;
    if (ev_q.size() != 0) begin n_fail++; $display("FAIL rst_mid_extra: got %0d extra events expected 0", ev_q.size()); end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_bypass();
    test_timeout_retry();
    test_overrun();
    test_done_at_timeout();
    test_saturation();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
